hilo_div_sequencer: RTL

- Multi-cycle divide sequencer for DIV/DIVU that owns the shared HI/LO result path.
- Accepts a divide request from the decode/issue side with operands taken after forwarding, and runs a radix-2 restoring division over WIDTH iterations.
- Stalls the front of the pipeline while busy, then presents {HI,LO} = {remainder, quotient} on a valid/ready handshake for the HI/LO write-back port.
- Can be cancelled by an exception flush.

---
 rtl/hilo_div_sequencer.sv | 106 ++++++++++
 1 files changed

// File: rtl/hilo_div_sequencer.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU that owns the {HI,LO} result path.
// State | meaning: IDLE | waiting for start; BUSY | one quotient bit per cycle; DONE | result held until res_ready.
module hilo_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    input  logic               flush,
    output logic               busy,
    output logic               stall,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] hilo_data
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count;
    logic [WIDTH-1:0] rem, quo, dvs_mag;
    logic            quo_neg, rem_neg;

    logic            dvd_neg, dvs_neg, accept, last_iter, step_ok;
    logic [WIDTH-1:0] dvd_abs, dvs_abs, rem_step, quo_step;
    logic [WIDTH:0]  rem_sh, diff;

    assign dvd_neg   = is_signed & dividend[WIDTH-1];
    assign dvs_neg   = is_signed & divisor[WIDTH-1];
    assign dvd_abs   = dvd_neg ? -dividend : dividend;
    assign dvs_abs   = dvs_neg ? -divisor  : divisor;
    assign accept    = (state == IDLE) && start && !flush;
    assign last_iter = (state == BUSY) && (count == CW'(1));

    // Trial subtract in WIDTH+1 bits: the borrow bit decides keep vs restore.
    assign rem_sh    = {rem, quo[WIDTH-1]};
    assign diff      = rem_sh - {1'b0, dvs_mag};
    assign step_ok   = ~diff[WIDTH];
    assign rem_step  = step_ok ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_step  = {quo[WIDTH-2:0], step_ok};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        res_valid = (state == DONE);
        stall     = accept || (state == BUSY) || ((state == DONE) && !res_ready);
        case (state)
            IDLE:    if (accept) state_nxt = (divisor == '0) ? DONE : BUSY;
            BUSY:    if (last_iter) state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count   <= '0;
            rem     <= '0;
            quo     <= '0;
            dvs_mag <= '0;
            quo_neg <= 1'b0;
            rem_neg <= 1'b0;
        end else if (accept) begin
            dvs_mag <= dvs_abs;
            quo_neg <= dvd_neg ^ dvs_neg;
            rem_neg <= dvd_neg;
            if (divisor == '0) begin
                // Divide by zero reports the raw dividend, no sign fix-up.
                rem   <= dividend;
                quo   <= '1;
                count <= '0;
            end else begin
                rem   <= '0;
                quo   <= dvd_abs;
                count <= CW'(WIDTH);
            end
        end else if ((state == BUSY) && !flush) begin
            count <= count - CW'(1);
            if (last_iter) begin
                rem <= rem_neg ? -rem_step : rem_step;
                quo <= quo_neg ? -quo_step : quo_step;
            end else begin
                rem <= rem_step;
                quo <= quo_step;
            end
        end
    end

    assign hilo_data = {rem, quo};

endmodule
